// File: rtl/sdram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter_if
// Bundles the two requester ports and the SDRAM-controller side of the
// two-port SDRAM arbiter.
//   p0_* / p1_*  : request, direction, address, write data, byte enables,
//                  one-cycle ack and held read data for each port
//   mem_*        : address, write data, read data, address/data strobes and
//                  read/write select towards the SDRAM controller
// Modports:
//   master : the requesters plus the memory model (drives requests and mem_dout)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface sdram_port_arbiter_if;
   logic        p0_req;
   logic        p0_we;
   logic [23:0] p0_addr;
   logic [15:0] p0_wdata;
   logic [1:0]  p0_be;
   logic        p0_ack;
   logic [15:0] p0_rdata;

   logic        p1_req;
   logic        p1_we;
   logic [23:0] p1_addr;
   logic [15:0] p1_wdata;
   logic [1:0]  p1_be;
   logic        p1_ack;
   logic [15:0] p1_rdata;

   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic [15:0] mem_dout;
   logic        mem_as;
   logic [1:0]  mem_ds;
   logic        mem_rw;
   logic        busy;
   logic [1:0]  grant;

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
      output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
      output mem_dout,
      input  p0_ack, p0_rdata, p1_ack, p1_rdata,
      input  mem_addr, mem_din, mem_as, mem_ds, mem_rw, busy, grant
   );

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
      input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
      input  mem_dout,
      output p0_ack, p0_rdata, p1_ack, p1_rdata,
      output mem_addr, mem_din, mem_as, mem_ds, mem_rw, busy, grant
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
// Round-robin arbiter giving two request ports turns at a strobe-driven SDRAM
// controller. Each access holds the strobes for ACCESS_CYCLES cycles, then
// keeps them low for RECOVER_CYCLES cycles before the next request is sampled.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : sdram_port_arbiter_if.slave (port requests/acks, memory strobes)
// All strobe, grant, busy and ack outputs come straight from flops.
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
   parameter int ACCESS_CYCLES  = 8,  // minimum 2
   parameter int RECOVER_CYCLES = 2   // minimum 1
) (
   input logic                  clock,
   input logic                  reset,
   sdram_port_arbiter_if.slave  bus
);

   localparam int MAX_CYCLES = (ACCESS_CYCLES > RECOVER_CYCLES) ? ACCESS_CYCLES : RECOVER_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;      // cycles remaining in the current state
   logic          owner, owner_nxt;  // 0 = p0, 1 = p1
   logic          last, last_nxt;    // last port served; reset to p1 so p0 wins first
   logic          load;
   logic          capture;
   logic [1:0]    ack_nxt;
   logic          sel_we;
   logic [23:0]   sel_addr;
   logic [15:0]   sel_wdata;
   logic [1:0]    sel_be;
   logic [1:0]    be_nxt;

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      owner_nxt = owner;
      last_nxt  = last;
      load      = 1'b0;
      capture   = 1'b0;
      ack_nxt   = 2'b00;

      unique case (state)
         IDLE: begin
            if (bus.p0_req || bus.p1_req) begin
               state_nxt = ACCESS;
               cnt_nxt   = CW'(ACCESS_CYCLES - 1);
               load      = 1'b1;
               // With both requesting, the port not served last wins.
               owner_nxt = (bus.p0_req && bus.p1_req) ? ~last : bus.p1_req;
            end
         end
         ACCESS: begin
            // cnt == 1 is the edge entering the final access cycle: the ack
            // and read data must be visible during that cycle.
            if (cnt == CW'(1)) begin
               ack_nxt[owner] = 1'b1;
               capture        = bus.mem_rw;
               last_nxt       = owner;
            end
            if (cnt == '0) begin
               state_nxt = RECOVER;
               cnt_nxt   = CW'(RECOVER_CYCLES - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         RECOVER: begin
            if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - CW'(1);
         end
         default: state_nxt = IDLE;
      endcase

      sel_we    = owner_nxt ? bus.p1_we    : bus.p0_we;
      sel_addr  = owner_nxt ? bus.p1_addr  : bus.p0_addr;
      sel_wdata = owner_nxt ? bus.p1_wdata : bus.p0_wdata;
      sel_be    = owner_nxt ? bus.p1_be    : bus.p0_be;
      // mem_ds carries the latched byte enables for the whole access.
      be_nxt    = load ? sel_be : bus.mem_ds;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         owner        <= 1'b0;
         last         <= 1'b1;
         bus.mem_addr <= '0;
         bus.mem_din  <= '0;
         bus.mem_rw   <= 1'b1;
         bus.mem_as   <= 1'b0;
         bus.mem_ds   <= 2'b00;
         bus.grant    <= 2'b00;
         bus.busy     <= 1'b0;
         bus.p0_ack   <= 1'b0;
         bus.p1_ack   <= 1'b0;
         bus.p0_rdata <= '0;
         bus.p1_rdata <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         owner      <= owner_nxt;
         last       <= last_nxt;
         bus.busy   <= (state_nxt != IDLE);
         bus.mem_as <= (state_nxt == ACCESS);
         bus.mem_ds <= (state_nxt == ACCESS) ? be_nxt : 2'b00;
         bus.grant  <= (state_nxt == ACCESS) ? (owner_nxt ? 2'b10 : 2'b01) : 2'b00;
         bus.p0_ack <= ack_nxt[0];
         bus.p1_ack <= ack_nxt[1];
         if (load) begin
            bus.mem_addr <= sel_addr;
            bus.mem_din  <= sel_wdata;
            bus.mem_rw   <= ~sel_we;
         end
         if (capture) begin
            if (owner) bus.p1_rdata <= bus.mem_dout;
            else       bus.p0_rdata <= bus.mem_dout;
         end
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Self-checking bench for sdram_port_arbiter. A transaction-level reference
// model tracks each access as a phase count since its request-sampled edge and
// derives every expected output from that count; directed scenarios are
// followed by randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;
   localparam int A = 8;
   localparam int R = 2;
   localparam int PERIOD_ACCESS = 1 + A + R;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   sdram_port_arbiter_if bus ();

   sdram_port_arbiter #(.ACCESS_CYCLES(A), .RECOVER_CYCLES(R)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state
   int          phase = 0;   // 0 = idle, 1..A = access, A+1..A+R = recover
   int          win   = 0;
   int          last  = 1;
   logic        m_we;
   logic [1:0]  m_be;
   logic [15:0] m_dout;
   logic [23:0] exp_addr;
   logic [15:0] exp_din;
   logic        exp_rw;
   logic [15:0] exp_rdata [2];

   int last_ack_cyc [2];
   int ack_times [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic cycle();
      logic        rst;
      logic [1:0]  rq;
      logic        wq [2];
      logic [23:0] aq [2];
      logic [15:0] dq [2];
      logic [1:0]  bq [2];
      logic [15:0] dout;
      logic        in_access;
      logic [1:0]  exp_ack;

      rst  = reset;
      rq   = {bus.p1_req, bus.p0_req};
      wq[0] = bus.p0_we;    wq[1] = bus.p1_we;
      aq[0] = bus.p0_addr;  aq[1] = bus.p1_addr;
      dq[0] = bus.p0_wdata; dq[1] = bus.p1_wdata;
      bq[0] = bus.p0_be;    bq[1] = bus.p1_be;
      dout = bus.mem_dout;

      @(posedge clock);
      cyc++;
      if (rst) begin
         phase = 0;
         last  = 1;
         exp_addr = '0;
         exp_din  = '0;
         exp_rw   = 1'b1;
         exp_rdata[0] = '0;
         exp_rdata[1] = '0;
      end else if (phase == 0) begin
         if (rq != 2'b00) begin
            if (rq == 2'b11) win = 1 - last;
            else             win = rq[1] ? 1 : 0;
            m_we     = wq[win];
            m_be     = bq[win];
            m_dout   = dout;
            exp_addr = aq[win];
            exp_din  = dq[win];
            exp_rw   = ~wq[win];
            phase    = 1;
         end
      end else begin
         phase++;
         if (phase > A + R) phase = 0;
      end
      if (!rst && phase == A) begin
         last = win;
         if (!m_we) exp_rdata[win] = m_dout;
      end

      #1;
      in_access = (phase >= 1 && phase <= A);
      exp_ack   = (!rst && phase == A) ? (win == 1 ? 2'b10 : 2'b01) : 2'b00;
      check("mem_as",   bus.mem_as, in_access);
      check("mem_ds",   bus.mem_ds, in_access ? m_be : 2'b00);
      check("grant",    bus.grant,  in_access ? (win == 1 ? 2'b10 : 2'b01) : 2'b00);
      check("busy",     bus.busy,   phase != 0);
      check("ack",      {bus.p1_ack, bus.p0_ack}, exp_ack);
      check("mem_rw",   bus.mem_rw,   exp_rw);
      check("mem_addr", bus.mem_addr, exp_addr);
      check("mem_din",  bus.mem_din,  exp_din);
      check("p0_rdata", bus.p0_rdata, exp_rdata[0]);
      check("p1_rdata", bus.p1_rdata, exp_rdata[1]);
      if (bus.p0_ack) begin last_ack_cyc[0] = cyc; ack_times.push_back(cyc); end
      if (bus.p1_ack) begin last_ack_cyc[1] = cyc; ack_times.push_back(cyc); end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic set_port(input int p, input logic req, input logic we,
                           input logic [23:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be);
      if (p == 0) begin
         bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_be = be;
      end else begin
         bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_be = be;
      end
   endtask

   task automatic randomize_port(input int p, input int req_pct);
      set_port(p, $urandom_range(99) < req_pct, 1'($urandom), 24'($urandom),
               16'($urandom), 2'($urandom));
   endtask

   initial begin
      int t0;
      reset = 1'b1;
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      bus.mem_dout = 16'h0000;
      cycles(3);
      reset = 1'b0;
      cycles(2);

      // Single p0 write: strobe one cycle after the sampled edge, ack in cycle A.
      set_port(0, 1, 1, 24'h000005, 16'h1234, 2'b11);
      t0 = cyc;
      cycles(A);
      check("p0_ack_latency", last_ack_cyc[0] - t0, A);
      bus.p0_req = 1'b0;
      cycles(R + 2);

      // p1 read returns mem_dout; p0_rdata stays at its reset value.
      bus.mem_dout = 16'hBEEF;
      set_port(1, 1, 0, 24'h00ABCD, 16'h0000, 2'b11);
      t0 = cyc;
      cycles(A);
      check("p1_ack_latency", last_ack_cyc[1] - t0, A);
      check("p1_rdata_beef", bus.p1_rdata, 16'hBEEF);
      check("p0_rdata_kept", bus.p0_rdata, 16'h0000);
      bus.p1_req = 1'b0;
      cycles(R + 2);

      // Both requesting from reset: alternate 01,10,01,10 with acks 1+A+R apart.
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      set_port(0, 1, 1, 24'h111111, 16'h1111, 2'b01);
      set_port(1, 1, 0, 24'h222222, 16'h2222, 2'b10);
      ack_times.delete();
      cycles(1);
      check("first_grant_p0", bus.grant, 2'b01);
      cycles(4 * PERIOD_ACCESS - 1);
      check("ack_count", ack_times.size(), 4);
      for (int i = 1; i < ack_times.size(); i++)
         check("ack_spacing", ack_times[i] - ack_times[i-1], PERIOD_ACCESS);
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      cycles(PERIOD_ACCESS);

      // p0 drops req mid-access while p1 inputs churn: access completes intact.
      set_port(0, 1, 0, 24'h0F0F0F, 16'h5A5A, 2'b11);
      bus.mem_dout = 16'hC0DE;
      t0 = cyc;
      cycles(2);
      bus.p0_req = 1'b0;
      for (int i = 0; i < A - 2; i++) begin
         set_port(1, 0, 1'($urandom), 24'($urandom), 16'($urandom), 2'($urandom));
         bus.p0_addr = 24'($urandom);
         cycle();
      end
      check("dropped_req_ack", last_ack_cyc[0] - t0, A);
      check("dropped_req_rdata", bus.p0_rdata, 16'hC0DE);
      cycles(R + 2);

      // Reset during access cycle 4 kills the access; next request goes to p0.
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 1, 1, 24'h333333, 16'h3333, 2'b11);
      cycles(4);
      reset = 1'b1;
      cycle();
      check("reset_mid_as", bus.mem_as, 1'b0);
      reset = 1'b0;
      set_port(0, 1, 1, 24'h444444, 16'h4444, 2'b11);
      cycle();
      check("post_reset_grant", bus.grant, 2'b01);
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      cycles(PERIOD_ACCESS);

      // be=00 read on p1 still runs a full access and acks.
      set_port(1, 1, 0, 24'h000777, 16'h0000, 2'b00);
      bus.mem_dout = 16'h7777;
      t0 = cyc;
      cycles(A);
      check("be00_ack", last_ack_cyc[1] - t0, A);
      bus.p1_req = 1'b0;
      cycles(R + 2);

      // Randomized traffic with occasional single-cycle resets.
      for (int i = 0; i < 3000; i++) begin
         randomize_port(0, 60);
         randomize_port(1, 60);
         if (phase == 0) bus.mem_dout = 16'($urandom);
         reset = ($urandom_range(199) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 8: clock cycles the downstream strobes are held per access (minimum 2).
REQ-002 SHALL have parameter RECOVER_CYCLES, default 2: strobe-low cycles between accesses (minimum 1).
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 pN_req  input  1  port N (N=0,1) request; held high until pN_ack.
REQ-006 pN_we  input  1  port N: 1=write, 0=read.
REQ-007 pN_addr  input  24  port N word address.
REQ-008 pN_wdata  input  16  port N write data.
REQ-009 pN_be  input  2  port N byte enables: [1]=upper, [0]=lower.
REQ-010 pN_ack  output  1  one-cycle completion pulse to port N.
REQ-011 pN_rdata  output  16  port N read data; valid in the pN_ack cycle and held until that port's next ack.
REQ-012 mem_addr  output  24  word address to the SDRAM controller.
REQ-013 mem_din  output  16  write data to the SDRAM controller.
REQ-014 mem_dout  input  16  read data from the SDRAM controller.
REQ-015 mem_as  output  1  address strobe, active-high.
REQ-016 mem_ds  output  2  data strobes, active-high: [1]=upper, [0]=lower.
REQ-017 mem_rw  output  1  1=read, 0=write.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 grant  output  2  one-hot owner of the current access; 00 when idle.

Function
REQ-020 SHALL implement states IDLE, ACCESS and RECOVER.
REQ-021 IDLE: if any pN_req is high, SHALL latch the winner's we/addr/wdata/be, set grant, load the cycle counter and go to ACCESS on the next edge.
REQ-022 Arbitration SHALL be round-robin. With a single requester, that requester wins. With both requesting, the port not served last wins. The last-served pointer SHALL favour p0 after reset.
REQ-023 ACCESS: mem_as=1, mem_ds=latched be, mem_rw=~latched we, mem_addr/mem_din=latched values, all stable for exactly ACCESS_CYCLES cycles.
REQ-024 In the final ACCESS cycle, SHALL capture mem_dout into the winner's pN_rdata if the access is a read, pulse the winner's pN_ack for one cycle, update the last-served pointer and go to RECOVER.
REQ-025 A write SHALL leave pN_rdata unchanged.
REQ-026 RECOVER: mem_as=0, mem_ds=00, grant=00 for exactly RECOVER_CYCLES cycles, then go to IDLE.
REQ-027 Request-to-strobe latency SHALL be 1 cycle.
REQ-028 Request-to-ack latency SHALL be ACCESS_CYCLES cycles (ack in cycle ACCESS_CYCLES after the req-sampled edge).
REQ-029 Back-to-back throughput SHALL be 1 + ACCESS_CYCLES + RECOVER_CYCLES cycles per access.
REQ-030 Requests SHALL be sampled only in IDLE. Port inputs changing during ACCESS SHALL have no effect.
REQ-031 A pN_req deasserted before ack SHALL NOT abort the access; the ack still pulses.
REQ-032 A pN_req still high in the cycle after its ack SHALL be treated as a new request.
REQ-033 be=00 SHALL still run a full access with mem_ds=00 and return an ack.
REQ-034 The cycle counter SHALL be wide enough for max(ACCESS_CYCLES, RECOVER_CYCLES) and SHALL NOT wrap within a state.
REQ-035 mem_as, mem_ds, mem_rw, grant, busy and pN_ack SHALL be registered outputs.

Reset
REQ-036 On reset, state SHALL go to IDLE, with mem_as=0, mem_ds=00, mem_rw=1, grant=00, busy=0, pN_ack=0, last-served pointer favouring p0.
REQ-037 On reset, mem_addr, mem_din and pN_rdata SHALL be 0.
REQ-038 Reset asserted mid-ACCESS SHALL drop the strobes on the next edge and SHALL NOT generate an ack.
REQ-039 reset SHALL take priority over every other transition.

Verification
REQ-040 p0 write addr=0x000005, wdata=0x1234, be=11 -> next cycle mem_as=1, mem_rw=0, mem_ds=11, mem_addr=0x000005, mem_din=0x1234 for 8 cycles; p0_ack pulse in the 8th cycle; then 2 cycles strobes low.
REQ-041 p1 read addr=0x00ABCD with mem_dout=0xBEEF -> mem_rw=1; p1_ack with p1_rdata=0xBEEF; p0_rdata unchanged.
REQ-042 p0 and p1 request together from reset and stay high -> grant sequence 01,10,01,10; each ack 11 cycles apart.
REQ-043 p0 req dropped after 2 ACCESS cycles -> access completes and p0_ack still pulses; p1 inputs toggled during the access -> mem_addr stable.
REQ-044 reset asserted in ACCESS cycle 4 -> next cycle mem_as=0, grant=00, busy=0, no ack; a following request is granted to p0.
REQ-045 be=00 read on p1 -> mem_ds=00 throughout the access and p1_ack asserted.
